// File: rtl/ofdm_tx_pkg.sv
// Shared constants, types and helpers for the OFDM TX cyclic-prefix framer.
package ofdm_tx_pkg;

    localparam int N_FFT   = 64;
    localparam int CP_LEN  = 16;
    localparam int DW      = 8;
    localparam int SYM_LEN = N_FFT + CP_LEN;
    localparam int DAC_W   = 14;
    localparam int AW      = $clog2(N_FFT);

    localparam logic [AW-1:0] CP_START  = AW'(N_FFT - CP_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_FFT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } iq_t;

    // DAC word keeps the top DW-1 bits of each rail; the LSB is simply truncated.
    function automatic logic [DAC_W-1:0] dac_pack(input iq_t s);
        return {s.re[DW-1:1], s.im[DW-1:1]};
    endfunction

endpackage

// File: rtl/ofdm_tx_cp_framer_if.sv
// Input sample stream from the IFFT into the framer (valid/ready handshake).
interface ofdm_tx_cp_framer_if;
    import ofdm_tx_pkg::*;

    logic [DW-1:0] ifft_din_re;
    logic [DW-1:0] ifft_din_im;
    logic [7:0]    ifft_din_index;
    logic          ifft_din_vld;
    logic          ifft_din_rdy;

    modport master (
        output ifft_din_re, ifft_din_im, ifft_din_index, ifft_din_vld,
        input  ifft_din_rdy
    );

    modport slave (
        input  ifft_din_re, ifft_din_im, ifft_din_index, ifft_din_vld,
        output ifft_din_rdy
    );

endinterface

// File: rtl/ofdm_tx_pingpong_ram.sv
// Two-bank simple dual-port sample RAM; the address MSB selects the bank, read data is registered.
module ofdm_tx_pingpong_ram
    import ofdm_tx_pkg::*;
(
    input  logic        Clk,
    input  logic        we,
    input  logic [AW:0] waddr,
    input  iq_t         wdata,
    input  logic        rd_en,
    input  logic [AW:0] raddr,
    output iq_t         rdata
);

    iq_t mem [2*N_FFT];

    // NOTE: the array has no reset so it maps onto block RAM; nothing downstream
    // looks at rdata until a bank has been fully written. Non-blocking writes
    // keep the read-before-write ordering identical in simulation and silicon.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ofdm_tx_cp_framer.sv
// Buffers IFFT symbols in a ping-pong RAM and replays each as cyclic prefix + body.
module ofdm_tx_cp_framer
    import ofdm_tx_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst_n,
    ofdm_tx_cp_framer_if.slave   din,
    output logic [DW-1:0]        tx_dout_re,
    output logic [DW-1:0]        tx_dout_im,
    output logic                 tx_dout_vld,
    output logic                 tx_dout_sos,
    output logic [DAC_W-1:0]     dac_data,
    output logic [15:0]          sym_cnt,
    output logic                 idx_err
);

    logic [1:0]    full;
    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] wr_addr;
    logic          accept, idx_match, idx_restart, wr_en, wr_done;
    iq_t           wr_data;

    rd_state_e     state, state_nxt;
    logic          rd_bank;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic          rd_en, rd_first, rd_done, other_ready;
    logic          pipe_vld, pipe_sos;
    iq_t           rd_data, out_s;

    assign din.ifft_din_rdy = ~full[wr_bank];
    assign accept      = din.ifft_din_vld & din.ifft_din_rdy;
    assign idx_match   = din.ifft_din_index == 8'(wr_cnt);
    assign idx_restart = ~idx_match & (din.ifft_din_index == 8'd0);
    assign wr_en       = accept & (idx_match | idx_restart);
    assign wr_addr     = idx_restart ? '0 : wr_cnt;
    assign wr_done     = wr_en & (wr_addr == LAST_ADDR);
    assign wr_data     = '{re: din.ifft_din_re, im: din.ifft_din_im};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            idx_err <= 1'b0;
        end else if (accept) begin
            if (!idx_match) begin
                idx_err <= 1'b1;
            end
            if (wr_done) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (wr_en) begin
                wr_cnt <= wr_addr + 1'b1;
            end
        end
    end

    // Writer and reader always own different banks, so set and clear never collide.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            full <= '0;
        end else begin
            if (wr_done) full[wr_bank] <= 1'b1;
            if (rd_done) full[rd_bank] <= 1'b0;
        end
    end

    // A bank completing on the reader's final BODY cycle still chains without a gap.
    assign other_ready = full[~rd_bank] | (wr_done & (wr_bank != rd_bank));

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        rd_en       = 1'b0;
        rd_first    = 1'b0;
        rd_done     = 1'b0;
        unique case (state)
            IDLE: begin
                rd_addr_nxt = CP_START;
                if (full[rd_bank]) state_nxt = CP;
            end
            CP: begin
                rd_en       = 1'b1;
                rd_first    = rd_addr == CP_START;
                rd_addr_nxt = rd_addr + 1'b1;
                if (rd_addr == LAST_ADDR) state_nxt = BODY;
            end
            BODY: begin
                rd_en       = 1'b1;
                rd_addr_nxt = rd_addr + 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    rd_done     = 1'b1;
                    rd_addr_nxt = CP_START;
                    state_nxt   = other_ready ? CP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_bank <= 1'b0;
            sym_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            if (rd_done) begin
                rd_bank <= ~rd_bank;
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

    ofdm_tx_pingpong_ram u_ram (
        .Clk   (Clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_addr}),
        .wdata (wr_data),
        .rd_en (rd_en),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data)
    );

    assign out_s = pipe_vld ? rd_data : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pipe_vld    <= 1'b0;
            pipe_sos    <= 1'b0;
            tx_dout_vld <= 1'b0;
            tx_dout_sos <= 1'b0;
            tx_dout_re  <= '0;
            tx_dout_im  <= '0;
            dac_data    <= '0;
        end else begin
            pipe_vld    <= rd_en;
            pipe_sos    <= rd_first;
            tx_dout_vld <= pipe_vld;
            tx_dout_sos <= pipe_sos;
            tx_dout_re  <= out_s.re;
            tx_dout_im  <= out_s.im;
            dac_data    <= dac_pack(out_s);
        end
    end

endmodule
